// File: rtl/decode_stage.sv
// decode_stage: in-order pipeline decode stage (IF/ID register, decoder,
// load-use hazard detection, ID/EX register).
//
// Ports:
//   clk, res            - clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc - fetch outputs, loaded into IF/ID unless stalled
//   flush               - execute-stage taken-branch kill
//   stall               - combinational; fetch holds PC/instr while high
//   Ra, Rb              - combinational register-file read addresses
//   ex_*                - registered ID/EX payload
//   stall_cnt           - saturating stall counter (only with DECODE_STALL_CNT_EN)
//
// Optional feature macro: DECODE_STALL_CNT_EN
module decode_stage (
    input  logic        clk,
    input  logic        res,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    output logic        stall,
    output logic [4:0]  Ra,
    output logic [4:0]  Rb,
    output logic        ex_valid,
    output logic [5:0]  ex_opcode,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_ra,
    output logic [4:0]  ex_rb,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic        ex_wr_en,
    output logic        ex_is_load
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 6;
    localparam int unsigned REGW  = 5;
    localparam int unsigned IMMW  = 16;

    localparam logic [OPW-1:0] OP_RALU   = 6'h00;
    localparam logic [OPW-1:0] OP_IALU   = 6'h01;
    localparam logic [OPW-1:0] OP_LOAD   = 6'h02;
    localparam logic [OPW-1:0] OP_STORE  = 6'h03;
    localparam logic [OPW-1:0] OP_BRANCH = 6'h04;

    // IF/ID register
    logic            ifid_valid_q;
    logic [XLEN-1:0] ifid_instr_q;
    logic [XLEN-1:0] ifid_pc_q;

    // ID/EX register
    logic            ex_valid_q, ex_valid_d;
    logic [OPW-1:0]  ex_opcode_q, ex_opcode_d;
    logic [REGW-1:0] ex_rd_q, ex_rd_d;
    logic [REGW-1:0] ex_ra_q, ex_ra_d;
    logic [REGW-1:0] ex_rb_q, ex_rb_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic            ex_wr_en_q, ex_wr_en_d;
    logic            ex_is_load_q, ex_is_load_d;

    // Decoded fields
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [IMMW-1:0] imm;
    logic            reads_a;
    logic            reads_b;
    logic            writes;
    logic            is_load;
    logic [REGW-1:0] rb_addr;
    logic            hazard;
    logic            issue;

    assign opcode = ifid_instr_q[31:26];
    assign rd     = ifid_instr_q[25:21];
    assign rs1    = ifid_instr_q[20:16];
    assign rs2    = ifid_instr_q[15:11];
    assign imm    = ifid_instr_q[15:0];

    // Opcode usage decode; unknown opcodes behave as NOP
    always_comb begin
        reads_a = 1'b0;
        reads_b = 1'b0;
        writes  = 1'b0;
        is_load = 1'b0;
        rb_addr = rs2;
        case (opcode)
            OP_RALU: begin
                reads_a = 1'b1;
                reads_b = 1'b1;
                writes  = 1'b1;
            end
            OP_IALU: begin
                reads_a = 1'b1;
                writes  = 1'b1;
            end
            OP_LOAD: begin
                reads_a = 1'b1;
                writes  = 1'b1;
                is_load = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                reads_a = 1'b1;
                reads_b = 1'b1;
                rb_addr = rd;
            end
            default: ;
        endcase
    end

    assign Ra = rs1;
    assign Rb = rb_addr;

    // Load-use hazard: the instruction in EX is a load whose destination is
    // read by the instruction in ID. Flush kills both, so no stall then.
    assign hazard = ex_valid_q && ex_is_load_q && (ex_rd_q != '0) && ifid_valid_q &&
                    ((reads_a && (ex_rd_q == rs1)) || (reads_b && (ex_rd_q == rb_addr)));
    assign stall  = hazard && !flush;

    // An instruction moves to EX only when valid and neither stalled nor flushed
    assign issue = ifid_valid_q && !stall && !flush;

    // ID/EX next-state; stall and flush insert a bubble via the control bits
    always_comb begin
        ex_valid_d   = issue;
        ex_opcode_d  = opcode;
        ex_rd_d      = rd;
        ex_ra_d      = rs1;
        ex_rb_d      = rb_addr;
        ex_imm_d     = {{(XLEN-IMMW){imm[IMMW-1]}}, imm};
        ex_pc_d      = ifid_pc_q;
        ex_wr_en_d   = issue && writes && (rd != '0);
        ex_is_load_d = issue && is_load;
    end

    // IF/ID register: holds while stalled; flush drops the fetched instruction
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else if (!stall) begin
            ifid_valid_q <= if_valid && !flush;
            ifid_instr_q <= if_instr;
            ifid_pc_q    <= if_pc;
        end
    end

    // ID/EX register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ex_valid_q   <= 1'b0;
            ex_opcode_q  <= '0;
            ex_rd_q      <= '0;
            ex_ra_q      <= '0;
            ex_rb_q      <= '0;
            ex_imm_q     <= '0;
            ex_pc_q      <= '0;
            ex_wr_en_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_rd_q      <= ex_rd_d;
            ex_ra_q      <= ex_ra_d;
            ex_rb_q      <= ex_rb_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc_q      <= ex_pc_d;
            ex_wr_en_q   <= ex_wr_en_d;
            ex_is_load_q <= ex_is_load_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_opcode  = ex_opcode_q;
    assign ex_rd      = ex_rd_q;
    assign ex_ra      = ex_ra_q;
    assign ex_rb      = ex_rb_q;
    assign ex_imm     = ex_imm_q;
    assign ex_pc      = ex_pc_q;
    assign ex_wr_en   = ex_wr_en_q;
    assign ex_is_load = ex_is_load_q;

`ifdef DECODE_STALL_CNT_EN
    localparam int unsigned CNTW = 16;

    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven directed bench for decode_stage, plus
// hand-written sequences for flush-over-stall, mid-stall reset and the
// optional stall counter (DECODE_STALL_CNT_EN).
module tb_decode_stage;

    logic        clk;
    logic        res;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        stall;
    logic [4:0]  Ra, Rb;
    logic        ex_valid;
    logic [5:0]  ex_opcode;
    logic [4:0]  ex_rd, ex_ra, ex_rb;
    logic [31:0] ex_imm, ex_pc;
    logic        ex_wr_en, ex_is_load;
`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk       (clk),
        .res       (res),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .flush     (flush),
        .stall     (stall),
        .Ra        (Ra),
        .Rb        (Rb),
        .ex_valid  (ex_valid),
        .ex_opcode (ex_opcode),
        .ex_rd     (ex_rd),
        .ex_ra     (ex_ra),
        .ex_rb     (ex_rb),
        .ex_imm    (ex_imm),
        .ex_pc     (ex_pc),
        .ex_wr_en  (ex_wr_en),
        .ex_is_load(ex_is_load)
`ifdef DECODE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] I_ADD   = 32'h00E51000; // ADD r7,r5,r2
    localparam logic [31:0] I_ADD2  = 32'h00E31000; // ADD r7,r3,r2
    localparam logic [31:0] I_LD    = 32'h08A10008; // LOAD r5,8(r1)
    localparam logic [31:0] I_IMM   = 32'h0464FFFC; // I-ALU r3,r4,-4
    localparam logic [31:0] I_ST    = 32'h0CC20004; // STORE r6,4(r2)
    localparam logic [31:0] I_ST5   = 32'h0CA20004; // STORE r5,4(r2)
    localparam logic [31:0] I_RD0   = 32'h00010800; // ADD r0,r1,r1
    localparam logic [31:0] I_NOPR5 = 32'hFC050000; // op 0x3F, rs1 field 5

    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic        fl;
        logic        stall;
        logic        chk_addr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        exv;
        logic        chk_data;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl);
        @(negedge clk);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        flush    = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // LOAD r5 then dependent ADD (re-presented once while stalled), then idle
    task automatic load_use_pair;
        drive(1'b1, I_LD, 32'h300, 1'b0);  tick();
        drive(1'b1, I_ADD, 32'h304, 1'b0); tick();
        drive(1'b1, I_ADD, 32'h304, 1'b0); tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);   tick();
    endtask

    initial begin
        res      = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        flush    = 1'b0;

        //            v     instr    fl    stl   ca    ra    rb     exv   cd    rd    wr    ld    imm
        vecs.push_back('{1'b1, I_ADD,   1'b0, 1'b0, 1'b1, 5'd5, 5'd2,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 32'h00001000});
        vecs.push_back('{1'b1, I_LD,    1'b0, 1'b0, 1'b1, 5'd1, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, I_ADD,   1'b0, 1'b1, 1'b1, 5'd5, 5'd2,  1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 32'h8});
        vecs.push_back('{1'b1, I_ADD,   1'b0, 1'b0, 1'b1, 5'd5, 5'd2,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, I_ADD2,  1'b0, 1'b0, 1'b1, 5'd3, 5'd2,  1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 32'h00001000});
        vecs.push_back('{1'b1, I_LD,    1'b0, 1'b0, 1'b1, 5'd1, 5'd0,  1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 32'h00001000});
        vecs.push_back('{1'b1, I_ADD2,  1'b0, 1'b0, 1'b1, 5'd3, 5'd2,  1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 32'h8});
        vecs.push_back('{1'b1, I_IMM,   1'b0, 1'b0, 1'b1, 5'd4, 5'd31, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 32'h00001000});
        vecs.push_back('{1'b1, I_ST,    1'b0, 1'b0, 1'b1, 5'd2, 5'd6,  1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 32'hFFFFFFFC});
        vecs.push_back('{1'b1, I_RD0,   1'b0, 1'b0, 1'b1, 5'd1, 5'd1,  1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 32'h4});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h00000800});
        vecs.push_back('{1'b1, I_LD,    1'b0, 1'b0, 1'b1, 5'd1, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, I_ST5,   1'b0, 1'b1, 1'b1, 5'd2, 5'd5,  1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 32'h8});
        vecs.push_back('{1'b1, I_ST5,   1'b0, 1'b0, 1'b1, 5'd2, 5'd5,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h4});
        vecs.push_back('{1'b1, I_LD,    1'b0, 1'b0, 1'b1, 5'd1, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, I_NOPR5, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0,  1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 32'h8});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, I_LD,    1'b0, 1'b0, 1'b1, 5'd1, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, I_ADD,   1'b0, 1'b1, 1'b1, 5'd5, 5'd2,  1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 32'h8});
        vecs.push_back('{1'b1, I_ADD,   1'b1, 1'b0, 1'b0, 5'd0, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 5'd0, 5'd0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_ra_rb", {22'h0, Ra, Rb}, 32'h0);
        @(negedge clk);
        res = 1'b1;

        // Directed vector table, checked after each edge
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].instr, 32'h100 + 32'(i * 4), vecs[i].fl);
            tick();
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].stall));
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].exv));
            chk($sformatf("v%0d_wr_en", i), 32'(ex_wr_en), 32'(vecs[i].wr));
            chk($sformatf("v%0d_is_load", i), 32'(ex_is_load), 32'(vecs[i].ld));
            if (vecs[i].chk_addr) begin
                chk($sformatf("v%0d_ra", i), 32'(Ra), 32'(vecs[i].ra));
                chk($sformatf("v%0d_rb", i), 32'(Rb), 32'(vecs[i].rb));
            end
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
                chk($sformatf("v%0d_ex_imm", i), ex_imm, vecs[i].imm);
            end
        end

        // Flush drops stall combinationally, before the edge
        drive(1'b1, I_LD, 32'h400, 1'b0);  tick();
        drive(1'b1, I_ADD, 32'h404, 1'b0); tick();
        chk("fl_stall_before", 32'(stall), 32'h1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_stall_comb", 32'(stall), 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);   tick();
        chk("fl_dropped", 32'(ex_valid), 32'h0);

        // Reset asserted mid-stall clears outputs immediately
        drive(1'b1, I_LD, 32'h500, 1'b0);  tick();
        drive(1'b1, I_ADD, 32'h504, 1'b0); tick();
        chk("mr_pre_stall", 32'(stall), 32'h1);
        chk("mr_pre_valid", 32'(ex_valid), 32'h1);
        @(negedge clk);
        #2;
        res = 1'b0;
        #1;
        chk("mr_stall", 32'(stall), 32'h0);
        chk("mr_ex_ctl", {29'h0, ex_valid, ex_wr_en, ex_is_load}, 32'h0);
        chk("mr_ex_rd_op", {21'h0, ex_opcode, ex_rd}, 32'h0);
        chk("mr_ex_imm", ex_imm, 32'h0);
        chk("mr_ex_pc", ex_pc, 32'h0);
        chk("mr_ra_rb", {22'h0, Ra, Rb}, 32'h0);
        drive(1'b1, I_ADD2, 32'h200, 1'b0);
        res = 1'b1;
        tick();
        chk("mr_fresh_ra", 32'(Ra), 32'd3);
        chk("mr_fresh_stall", 32'(stall), 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);   tick();
        chk("mr_fresh_valid", 32'(ex_valid), 32'h1);
        chk("mr_fresh_rd", 32'(ex_rd), 32'd7);
        chk("mr_fresh_srcs", {22'h0, ex_ra, ex_rb}, {22'h0, 5'd3, 5'd2});
        chk("mr_fresh_op", 32'(ex_opcode), 32'h0);
        chk("mr_fresh_pc", ex_pc, 32'h200);

`ifdef DECODE_STALL_CNT_EN
        chk("cnt_after_reset", 32'(stall_cnt), 32'h0);
        repeat (3) load_use_pair();
        chk("cnt_three", 32'(stall_cnt), 32'd3);
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        load_use_pair();
        chk("cnt_reach_max", 32'(stall_cnt), 32'h0000FFFF);
        load_use_pair();
        chk("cnt_saturate", 32'(stall_cnt), 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
